// File: rtl/pre_come_qualifier_if.sv
// Avalon-MM register bus of the pre-come qualifier.
interface pre_come_qualifier_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pre_come_qualifier.sv
// Synchronizes and debounces the raw pre-come pin into a clean level for the PIO,
// with an Avalon-MM block for control, threshold, event count and status.
module pre_come_qualifier #(
  parameter int CNT_W          = 16,
  parameter int DEFAULT_STABLE = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 raw_in,
  pre_come_qualifier_if.slave  avs,
  output logic                 qual_out
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    QUAL_HIGH = 2'd1,
    HIGH      = 2'd2,
    QUAL_LOW  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_RST = CNT_W'(DEFAULT_STABLE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thresh_q;
  logic [CNT_W-1:0] eff_thresh_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [1:0]       ctrl_q;
  logic [31:0]      event_cnt_q;
  logic [31:0]      readdata_q, readdata_d;
  logic             qual_q;
  logic             sync1_q, sync2_q;
  logic             wr_s, inc_s, in_s, qualifying_s;
  logic             unused_wdata_s;

  assign wr_s           = avs.chipselect & ~avs.write_n;
  assign in_s           = sync2_q ^ ctrl_q[1];
  assign eff_thresh_s   = (thresh_q == CNT_ZERO) ? CNT_ONE : thresh_q;
  assign cnt_inc_s      = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
  assign qualifying_s   = (state_q == QUAL_HIGH) || (state_q == QUAL_LOW);
  assign unused_wdata_s = ^avs.writedata;
  assign qual_out       = qual_q;
  assign avs.readdata   = readdata_q;

  // two-flop synchronizer on the asynchronous pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // control and threshold registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= 2'b01;
      thresh_q <= THRESH_RST;
    end else if (wr_s && (avs.address == 2'd0)) begin
      ctrl_q <= avs.writedata[1:0];
    end else if (wr_s && (avs.address == 2'd1)) begin
      thresh_q <= avs.writedata[CNT_W-1:0];
    end
  end

  // debounce next-state; disable parks the machine low regardless of input
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc_s   = 1'b0;
    if (!ctrl_q[0]) begin
      state_d = IDLE_LOW;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE_LOW: begin
          if (in_s) begin
            state_d = QUAL_HIGH;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE_LOW;
          end
        end
        QUAL_HIGH: begin
          if (!in_s) begin
            state_d = IDLE_LOW;
          end else if (cnt_q >= eff_thresh_s) begin
            state_d = HIGH;
            inc_s   = 1'b1;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        HIGH: begin
          if (!in_s) begin
            state_d = QUAL_LOW;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = HIGH;
          end
        end
        QUAL_LOW: begin
          if (in_s) begin
            state_d = HIGH;
          end else if (cnt_q >= eff_thresh_s) begin
            state_d = IDLE_LOW;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        default: begin
          state_d = IDLE_LOW;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // debounce state, counter and the registered output level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= CNT_ZERO;
      qual_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qual_q  <= (state_d == HIGH) || (state_d == QUAL_LOW);
    end
  end

  // qualified-rise counter; a clear write beats a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_cnt_q <= 32'd0;
    end else if (wr_s && (avs.address == 2'd2)) begin
      event_cnt_q <= 32'd0;
    end else if (inc_s && (event_cnt_q != 32'hFFFF_FFFF)) begin
      event_cnt_q <= event_cnt_q + 32'd1;
    end
  end

  // read mux
  always_comb begin
    readdata_d = 32'd0;
    case (avs.address)
      2'd0:    readdata_d = {30'd0, ctrl_q};
      2'd1:    readdata_d = 32'(thresh_q);
      2'd2:    readdata_d = event_cnt_q;
      2'd3:    readdata_d = {29'd0, qualifying_s, qual_q, in_s};
      default: readdata_d = 32'd0;
    endcase
  end

  // registered read data, one-cycle latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= 32'd0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_pre_come_qualifier.sv
// Directed bench for pre_come_qualifier: a run-length debounce model checks
// qual_out and readdata every cycle, plus literal latency/count expectations.
module tb_pre_come_qualifier;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic raw_in  = 1'b0;
  logic qual_out;

  pre_come_qualifier_if bus();

  pre_come_qualifier #(.CNT_W(16), .DEFAULT_STABLE(1000)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_in   (raw_in),
    .avs      (bus),
    .qual_out (qual_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // model state: output level, length of the current disagreeing run, registers
  logic        m_level;
  int          m_run;
  logic [31:0] m_evt;
  logic        m_en, m_inv;
  logic [15:0] m_thresh;
  logic        m_sync1, m_sync2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_level  = 1'b0;
    m_run    = 0;
    m_evt    = 32'd0;
    m_en     = 1'b1;
    m_inv    = 1'b0;
    m_thresh = 16'd1000;
    m_sync1  = 1'b0;
    m_sync2  = 1'b0;
  endtask

  // one clock: predict from pre-edge inputs, step, then compare after the edge
  task automatic tick();
    logic        s;
    logic        rise;
    logic        wr;
    int          n;
    logic [31:0] rd;
    s = m_sync2 ^ m_inv;
    n = (m_thresh == 16'd0) ? 1 : int'(m_thresh);
    case (bus.address)
      2'd0:    rd = {30'd0, m_inv, m_en};
      2'd1:    rd = {16'd0, m_thresh};
      2'd2:    rd = m_evt;
      default: rd = {29'd0, (m_run > 0), m_level, s};
    endcase
    rise = 1'b0;
    if (!m_en) begin
      m_level = 1'b0;
      m_run   = 0;
    end else if (s == m_level) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run > n) begin
        m_level = ~m_level;
        m_run   = 0;
        rise    = m_level;
      end
    end
    wr = bus.chipselect && !bus.write_n;
    if (wr && bus.address == 2'd2) m_evt = 32'd0;
    else if (rise && m_evt != 32'hFFFF_FFFF) m_evt = m_evt + 32'd1;
    if (wr && bus.address == 2'd0) begin
      m_en  = bus.writedata[0];
      m_inv = bus.writedata[1];
    end
    if (wr && bus.address == 2'd1) m_thresh = bus.writedata[15:0];
    m_sync2 = m_sync1;
    m_sync1 = raw_in;
    @(posedge clk);
    #1;
    chk("qual_out", {31'd0, qual_out}, {31'd0, m_level});
    chk("readdata", bus.readdata, rd);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic read_lit(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.address = a;
    tick();
    chk(name, bus.readdata, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_qual_out", {31'd0, qual_out}, 32'd0);
    chk("rst_readdata", bus.readdata, 32'd0);
    m_reset();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    int edge_at;
    int hi;
    int min_hi;
    logic seen;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    m_reset();
    #1;
    do_reset();
    read_lit(2'd0, 32'd1, "rst_ctrl");
    read_lit(2'd1, 32'd1000, "rst_thresh");

    // default threshold: held-high pin qualifies after edge 1003
    bus.address = 2'd3;
    raw_in = 1'b1;
    for (int i = 1; i <= 1003; i++) begin
      tick();
      if (i == 1002) chk("t1_low_at_1002", {31'd0, qual_out}, 32'd0);
      if (i == 1003) chk("t1_high_at_1003", {31'd0, qual_out}, 32'd1);
    end
    read_lit(2'd2, 32'd1, "t1_evt");
    raw_in = 1'b0;
    repeat (1010) tick();

    // threshold 4, 3-cycle glitch must not qualify
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd0);
    bus.address = 2'd3;
    seen = 1'b0;
    raw_in = 1'b1;
    repeat (3) tick();
    raw_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.readdata[2]) seen = 1'b1;
    end
    chk("t2_status_qualifying_seen", {31'd0, seen}, 32'd1);
    read_lit(2'd2, 32'd0, "t2_evt");

    // rise and fall each 7 edges after the pin change; a 2-cycle dip is filtered
    edge_at = 0;
    raw_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (qual_out && edge_at == 0) edge_at = i;
    end
    chk("t3_rise_edge", edge_at, 32'd7);
    seen = 1'b0;
    raw_in = 1'b0;
    repeat (2) tick();
    raw_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!qual_out) seen = 1'b1;
    end
    chk("t3_dip_filtered", {31'd0, seen}, 32'd0);
    edge_at = 0;
    raw_in = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (!qual_out && edge_at == 0) edge_at = i;
    end
    chk("t3_fall_edge", edge_at, 32'd7);

    // threshold 0 acts as 1: 2-cycle pulses qualify, high for 2 cycles
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd0);
    min_hi = 99;
    for (int p = 0; p < 3; p++) begin
      hi = 0;
      raw_in = 1'b1;
      tick();
      hi += int'(qual_out);
      tick();
      hi += int'(qual_out);
      raw_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        hi += int'(qual_out);
      end
      if (hi < min_hi) min_hi = hi;
    end
    chk("t4_min_high", min_hi, 32'd2);
    raw_in = 1'b1;
    tick();
    raw_in = 1'b0;
    repeat (6) tick();
    read_lit(2'd2, 32'd3, "t4_evt");

    // disable drops the output next cycle; inverted re-enable qualifies after N+1
    wr(2'd1, 32'd4);
    raw_in = 1'b1;
    repeat (10) tick();
    chk("t5_high_before_disable", {31'd0, qual_out}, 32'd1);
    wr(2'd0, 32'd0);
    tick();
    chk("t5_low_after_disable", {31'd0, qual_out}, 32'd0);
    raw_in = 1'b0;
    repeat (4) tick();
    wr(2'd0, 32'd3);
    edge_at = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (qual_out && edge_at == 0) edge_at = i;
    end
    chk("t5_invert_rise", edge_at, 32'd5);
    wr(2'd0, 32'd1);
    repeat (8) tick();

    // preload 5 events, then clear on the same edge as a qualifying rise
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd0);
    for (int p = 0; p < 5; p++) begin
      raw_in = 1'b1;
      repeat (2) tick();
      raw_in = 1'b0;
      repeat (5) tick();
    end
    read_lit(2'd2, 32'd5, "t6_evt_preload");
    raw_in = 1'b1;
    repeat (3) tick();
    wr(2'd2, 32'd0);
    chk("t6_rise_on_clear", {31'd0, qual_out}, 32'd1);
    read_lit(2'd2, 32'd0, "t6_clear_wins");

    // asynchronous reset in the middle of a high qualification
    raw_in = 1'b0;
    repeat (5) tick();
    wr(2'd1, 32'd10);
    bus.address = 2'd1;
    raw_in = 1'b1;
    repeat (5) tick();
    chk("t6_pre_reset_rd", bus.readdata, 32'd10);
    #2;
    raw_in = 1'b0;
    do_reset();
    read_lit(2'd0, 32'd1, "t6_ctrl_after_rst");
    read_lit(2'd1, 32'd1000, "t6_thresh_after_rst");
    read_lit(2'd2, 32'd0, "t6_evt_after_rst");
    read_lit(2'd3, 32'd0, "t6_status_after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
